uart_rx: RTL and testbench

//  8N1 UART receiver; the receive-side counterpart of the core's UART transmit path.

---
 rtl/uart_defs_pkg.sv | 21 ++
 rtl/uart_rx_fifo.sv | 58 +++++
 rtl/uart_rx.sv | 143 ++++++++++++++
 tb/tb_uart_rx.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_defs_pkg.sv
// uart_defs: shared definitions for the UART receive path.
//   rx_state_t        receiver FSM state encoding
//   CLKS_PER_BIT_DEF  default clocks per bit (100 MHz / 9600 baud)
//   UART_BITS         data bits per frame
//   maj3()            2-of-3 majority vote used by the optional majority sampler
package uart_defs;
  localparam int UART_BITS        = 8;
  localparam int CLKS_PER_BIT_DEF = 10416;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_STOP    = 3'd3,
    ST_WAIT_HI = 3'd4
  } rx_state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through byte FIFO behind the UART receiver.
//   clk_100MHz  in   system clock
//   reset       in   active-low async reset
//   push        in   write din this cycle
//   din         in   byte to write
//   rd          in   pop request, ignored while empty
//   dout        out  head byte (0 while empty)
//   vdout       out  FIFO not empty
//   level       out  bytes held, 0..2**AW
//   ovf         out  1-cycle pulse one cycle after a push was dropped (full, no pop)
module uart_rx_fifo #(
  parameter int AW = 4,
  parameter int W  = 8
) (
  input  logic          clk_100MHz,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          rd,
  output logic [W-1:0]  dout,
  output logic          vdout,
  output logic [AW:0]   level,
  output logic          ovf
);
  localparam int DEPTH = 2 ** AW;

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr, rptr;
  logic         empty, full, pop, wr_en;

  // Extra pointer MSB distinguishes full from empty when low bits match.
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop   = rd && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk_100MHz) begin
    if (wr_en) mem[wptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
      ovf  <= 1'b0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (pop)   rptr <= rptr + 1'b1;
      ovf <= push && full && !pop;
    end
  end

  // Memory is not reset; gating keeps dout at 0 whenever nothing is held.
  assign dout  = empty ? '0 : mem[rptr[AW-1:0]];
  assign vdout = !empty;
  assign level = wptr - rptr;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a FWFT receive FIFO.
//   clk_100MHz  in   system clock
//   reset       in   active-low reset, async assert / sync release
//   rxd         in   serial input, idle high, asynchronous
//   rd          in   pop request, honoured when vdout=1
//   dout        out  FIFO head byte
//   vdout       out  FIFO not empty
//   level       out  bytes held
//   frame_err   out  1-cycle pulse: stop bit sampled low, byte discarded
//   ovf         out  1-cycle pulse: good byte dropped because the FIFO was full
// Build option: define UART_RX_MAJORITY_EN to take a 2-of-3 vote of rxs around
// every sample point (decision one cycle after the point).
module uart_rx
  import uart_defs::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int FIFO_AW      = 4
) (
  input  logic               clk_100MHz,
  input  logic               reset,
  input  logic               rxd,
  input  logic               rd,
  output logic [7:0]         dout,
  output logic               vdout,
  output logic [FIFO_AW:0]   level,
  output logic               frame_err,
  output logic               ovf
);
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif
  localparam int CW = $clog2(CLKS_PER_BIT);
  // All decision points move one cycle later in majority mode; only the
  // start decision needs the shift, bit spacing follows from it.
  localparam logic [CW-1:0] START_PT = CW'(CLKS_PER_BIT / 2 - 1 + MAJ);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);

  logic [1:0]  rst_sync;
  logic        rst_n;
  logic        rx_meta, rxs, smp;
  rx_state_t   state, state_nxt;
  logic [CW-1:0] cnt;
  logic [2:0]  bit_idx;
  logic [UART_BITS-1:0] shreg, push_byte;
  logic        push_q;
  logic        start_pt, bit_pt, shift_en, stop_ok, stop_bad;

  // Reset asserts asynchronously, releases two clocks after reset rises.
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic rxs_d1, rxs_d2;
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      rxs_d1 <= 1'b1;
      rxs_d2 <= 1'b1;
    end else begin
      rxs_d1 <= rxs;
      rxs_d2 <= rxs_d1;
    end
  end
  // Evaluated at point+1: rxs_d2/rxs_d1/rxs are the values at point-1/point/point+1.
  assign smp = maj3(rxs_d2, rxs_d1, rxs);
`else
  assign smp = rxs;
`endif

  // FSM: state register
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (!rxs) state_nxt = ST_START;
      ST_START:   if (start_pt) state_nxt = smp ? ST_IDLE : ST_DATA;
      ST_DATA:    if (bit_pt && bit_idx == 3'(UART_BITS - 1)) state_nxt = ST_STOP;
      ST_STOP:    if (bit_pt) state_nxt = smp ? ST_IDLE : ST_WAIT_HI;
      ST_WAIT_HI: if (rxs) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // FSM: decoded strobes
  always_comb begin
    start_pt = (state == ST_START) && (cnt == START_PT);
    bit_pt   = ((state == ST_DATA) || (state == ST_STOP)) && (cnt == BIT_END);
    shift_en = (state == ST_DATA) && bit_pt;
    stop_ok  = (state == ST_STOP) && bit_pt && smp;
    stop_bad = (state == ST_STOP) && bit_pt && !smp;
  end

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      push_q    <= 1'b0;
      push_byte <= '0;
      frame_err <= 1'b0;
    end else begin
      if (state == ST_IDLE || state == ST_WAIT_HI || start_pt || bit_pt) cnt <= '0;
      else                                                               cnt <= cnt + 1'b1;
      if (start_pt)      bit_idx <= '0;
      else if (shift_en) bit_idx <= bit_idx + 1'b1;
      if (shift_en) shreg <= {smp, shreg[UART_BITS-1:1]};
      push_q    <= stop_ok;
      push_byte <= shreg;
      frame_err <= stop_bad;
    end
  end

  uart_rx_fifo #(.AW(FIFO_AW), .W(UART_BITS)) u_fifo (
    .clk_100MHz (clk_100MHz),
    .reset      (rst_n),
    .push       (push_q),
    .din        (push_byte),
    .rd         (rd),
    .dout       (dout),
    .vdout      (vdout),
    .level      (level),
    .ovf        (ovf)
  );
endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;
  localparam int CPB = 16;
  localparam int H   = CPB / 2;
  localparam int AW  = 4;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif
  // Frame-relative cycle in which the received byte is written to the FIFO.
  localparam int PUSH_AT = 3 + H + 9 * CPB + MAJ;

  logic          clk_100MHz = 1'b0;
  logic          reset = 1'b0;
  logic          rxd = 1'b1;
  logic          rd = 1'b0;
  logic [7:0]    dout;
  logic          vdout;
  logic [AW:0]   level;
  logic          frame_err, ovf;

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  int ovf_cnt = 0;
  logic [7:0] exp_q[$];

  uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .rxd        (rxd),
    .rd         (rd),
    .dout       (dout),
    .vdout      (vdout),
    .level      (level),
    .frame_err  (frame_err),
    .ovf        (ovf)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  always @(negedge clk_100MHz) begin
    if (frame_err === 1'b1) fe_cnt++;
    if (ovf === 1'b1) ovf_cnt++;
    if (frame_err === 1'b1 && ovf === 1'b1) begin
      errors++;
      $display("FAIL excl_flags: frame_err=%b ovf=%b same cycle, required not both", frame_err, ovf);
    end
  end

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk_100MHz);
    #1;
  endtask

  // Drives one 10-bit frame, one rxd value per clock. Optional 1-clk high glitch
  // at each data-bit sample point, and optional rd pulse at frame cycle rd_at,
  // where the popped head is checked against the scoreboard.
  task automatic send_frame(input logic [7:0] b, input bit stop_b, input bit glitch, input int rd_at);
    logic [9:0] fr;
    logic [7:0] e;
    fr = {stop_b, b, 1'b0};
    for (int c = 0; c < 10 * CPB; c++) begin
      @(posedge clk_100MHz); #1;
      rxd = fr[c / CPB];
      if (glitch)
        for (int i = 0; i < 8; i++) if (c == H + (i + 1) * CPB) rxd = 1'b1;
      if (c == rd_at) begin
        rd = 1'b1;
        checks++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        if (dout !== e) begin
          errors++;
          $display("FAIL same_cycle_pop: dout=%h required %h", dout, e);
        end
      end else rd = 1'b0;
    end
  endtask

  task automatic pop_check(input string nm);
    int n;
    logic [7:0] e;
    n = 0;
    while (vdout !== 1'b1 && n < 30 * CPB) begin @(negedge clk_100MHz); n++; end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, vdout=%b dout=%h", nm, vdout, dout);
    end else begin
      e = exp_q.pop_front();
      if (vdout !== 1'b1 || dout !== e) begin
        errors++;
        $display("FAIL %s: vdout=%b dout=%h required vdout=1 dout=%h", nm, vdout, dout, e);
      end
    end
    @(posedge clk_100MHz); #1 rd = 1'b1;
    @(posedge clk_100MHz); #1 rd = 1'b0;
  endtask

  task automatic test_reset;
    cycles(3);
    checks++;
    if (dout !== 8'h00 || vdout !== 1'b0 || level !== '0 || frame_err !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: dout=%h vdout=%b level=%0d fe=%b ovf=%b required all 0",
               dout, vdout, level, frame_err, ovf);
    end
    #2 reset = 1'b1;
    cycles(5);
  endtask

  task automatic test_basic;
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, 1'b0, -1);
    @(negedge clk_100MHz);
    checks++;
    if (level !== 5'd1) begin
      errors++;
      $display("FAIL basic_level: level=%0d required 1", level);
    end
    pop_check("basic_byte");
    @(negedge clk_100MHz);
    checks++;
    if (vdout !== 1'b0 || level !== 5'd0) begin
      errors++;
      $display("FAIL basic_after_pop: vdout=%b level=%0d required 0 0", vdout, level);
    end
  endtask

  task automatic test_start_glitch;
    int fe0;
    fe0 = fe_cnt;
    @(posedge clk_100MHz); #1 rxd = 1'b0;
    cycles(4);
    rxd = 1'b1;
    cycles(3 * CPB);
    @(negedge clk_100MHz);
    checks++;
    if (level !== 5'd0 || fe_cnt != fe0) begin
      errors++;
      $display("FAIL start_glitch: level=%0d fe_pulses=%0d required 0 0", level, fe_cnt - fe0);
    end
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 1'b0, -1);
    pop_check("after_glitch");
  endtask

  task automatic test_frame_err;
    int fe0;
    fe0 = fe_cnt;
    send_frame(8'hA3, 1'b0, 1'b0, -1);
    cycles(2);
    @(negedge clk_100MHz);
    checks++;
    if (fe_cnt - fe0 != 1 || level !== 5'd0) begin
      errors++;
      $display("FAIL frame_err: pulses=%0d level=%0d required 1 0", fe_cnt - fe0, level);
    end
    cycles(200);
    rxd = 1'b1;
    cycles(2 * CPB);
    @(negedge clk_100MHz);
    checks++;
    if (fe_cnt - fe0 != 1 || level !== 5'd0) begin
      errors++;
      $display("FAIL break_hold: pulses=%0d level=%0d required 1 0", fe_cnt - fe0, level);
    end
    exp_q.push_back(8'h01);
    send_frame(8'h01, 1'b1, 1'b0, -1);
    pop_check("after_break");
  endtask

  task automatic test_overflow;
    int ov0, ov_before;
    ov0 = ovf_cnt;
    ov_before = 0;
    for (int b = 0; b < 17; b++) begin
      if (b < 16) exp_q.push_back(8'(b));
      else ov_before = ovf_cnt - ov0;
      send_frame(8'(b), 1'b1, 1'b0, -1);
    end
    @(negedge clk_100MHz);
    checks++;
    if (ov_before != 0 || ovf_cnt - ov0 != 1 || level !== 5'd16) begin
      errors++;
      $display("FAIL ovf_17th: ovf_before=%0d ovf_total=%0d level=%0d required 0 1 16",
               ov_before, ovf_cnt - ov0, level);
    end
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 1'b0, PUSH_AT);
    @(negedge clk_100MHz);
    checks++;
    if (ovf_cnt - ov0 != 1 || level !== 5'd16) begin
      errors++;
      $display("FAIL full_push_pop: ovf_total=%0d level=%0d required 1 16", ovf_cnt - ov0, level);
    end
    for (int i = 0; i < 16; i++) pop_check("drain");
    @(negedge clk_100MHz);
    checks++;
    if (vdout !== 1'b0 || level !== 5'd0) begin
      errors++;
      $display("FAIL drained: vdout=%b level=%0d required 0 0", vdout, level);
    end
  endtask

  task automatic test_reset_midframe;
    logic [9:0] fr;
    send_frame(8'h11, 1'b1, 1'b0, -1);
    fr = {1'b1, 8'h7E, 1'b0};
    for (int c = 0; c < 5 * CPB + H; c++) begin
      @(posedge clk_100MHz); #1;
      rxd = fr[c / CPB];
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (dout !== 8'h00 || vdout !== 1'b0 || level !== '0 || frame_err !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL midframe_reset: dout=%h vdout=%b level=%0d fe=%b ovf=%b required all 0",
               dout, vdout, level, frame_err, ovf);
    end
    exp_q.delete();
    rxd = 1'b1;
    cycles(3);
    #2 reset = 1'b1;
    cycles(5);
    exp_q.push_back(8'h42);
    send_frame(8'h42, 1'b1, 1'b0, -1);
    @(negedge clk_100MHz);
    checks++;
    if (level !== 5'd1) begin
      errors++;
      $display("FAIL post_reset_level: level=%0d required 1", level);
    end
    pop_check("post_reset_byte");
  endtask

  task automatic test_majority;
`ifdef UART_RX_MAJORITY_EN
    exp_q.push_back(8'h00);
`else
    exp_q.push_back(8'hFF);
`endif
    send_frame(8'h00, 1'b1, 1'b1, -1);
    pop_check("glitched_zero");
  endtask

  task automatic test_back_to_back;
    logic [7:0] s [3];
    s = '{8'h48, 8'h69, 8'h0A};
    foreach (s[i]) begin
      exp_q.push_back(s[i]);
      send_frame(s[i], 1'b1, 1'b0, -1);
    end
    @(negedge clk_100MHz);
    checks++;
    if (level !== 5'd3) begin
      errors++;
      $display("FAIL b2b_level: level=%0d required 3", level);
    end
    for (int i = 0; i < 3; i++) pop_check("b2b_string");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_start_glitch();
    test_frame_err();
    test_overflow();
    test_reset_midframe();
    test_majority();
    test_back_to_back();
    cycles(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
